// File: rtl/io_walk_sequencer_pkg.sv
// Shared types and pin-map constants for the IO walk bring-up sequencer.
package io_walk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WALK1 = 2'd1,
        ST_WALK0 = 2'd2,
        ST_DONE  = 2'd3
    } walk_state_e;

    localparam int START_PIN      = 0;
    localparam int STATUS_PIN     = 1;
    localparam int FIRST_TEST_PIN = 2;
    localparam int ERR_W          = 8;

    // Error count sticks at all-ones instead of wrapping back to a clean-looking value.
    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        if (v == {ERR_W{1'b1}}) begin
            return v;
        end
        return v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/io_walk_sequencer_if.sv
// Pad bus between the wrapper and the sequencer: inputs, outputs and output-enable bar.
interface io_walk_sequencer_if #(
    parameter int NUM_IO = 31
);
    logic [NUM_IO-1:0] io_in;
    logic [NUM_IO-1:0] io_out;
    logic [NUM_IO-1:0] io_oeb;

    // master = sequencer driving the pads, slave = pad ring / wrapper side
    modport master (input io_in, output io_out, output io_oeb);
    modport slave  (output io_in, input io_out, input io_oeb);
endinterface

// File: rtl/io_walk_sequencer_start_sync.sv
// Start pin synchronizer: two metastability flops, then a registered one-cycle rising-edge pulse.
module io_start_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);
    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic pulse_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= d_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pulse_q <= s2_q & ~s3_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/io_walk_sequencer.sv
// Bring-up controller: walks a one then a zero across the test pins, checks pad loopback,
// and reports an error count plus pass/fail blink on the pins themselves.
module io_walk_sequencer
    import io_walk_pkg::*;
#(
    parameter int NUM_IO      = 31,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    io_walk_sequencer_if.master pads
);
    localparam int W      = NUM_IO - FIRST_TEST_PIN;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);
    localparam int K_W    = $clog2(W);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [K_W-1:0]    K_LAST    = K_W'(W - 1);
    localparam logic [W-1:0]      ONE_W     = {{(W-1){1'b0}}, 1'b1};

    walk_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              blink_q, blink_d;

    logic              start_pulse;
    logic              hold_last;
    logic              step_mismatch;
    logic [W-1:0]      pattern;
    logic              unused_status_in;

    io_start_sync u_start_sync (
        .clk     (clk),
        .rst     (rst),
        .d_i     (pads.io_in[START_PIN]),
        .pulse_o (start_pulse)
    );

    assign unused_status_in = pads.io_in[STATUS_PIN];

    assign hold_last = (hold_q == HOLD_LAST);
    assign pattern   = (state_q == ST_WALK0) ? ~(ONE_W << k_q) : (ONE_W << k_q);
    // Only meaningful in the walk states; the loopback compare never reaches an output directly.
    assign step_mismatch = (pads.io_in[NUM_IO-1:FIRST_TEST_PIN] != pattern);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            k_q     <= '0;
            err_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            k_q     <= k_d;
            err_q   <= err_d;
            blink_q <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        k_d     = k_q;
        err_d   = err_q;
        blink_d = blink_q;

        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d = ST_WALK1;
                    hold_d  = '0;
                    k_d     = '0;
                    err_d   = '0;
                    blink_d = 1'b0;
                end
            end

            ST_WALK1, ST_WALK0: begin
                if (hold_last) begin
                    hold_d = '0;
                    if (step_mismatch) begin
                        err_d = err_sat_inc(err_q);
                    end
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        if (state_q == ST_WALK1) begin
                            state_d = ST_WALK0;
                        end else begin
                            state_d = ST_DONE;
                            blink_d = 1'b1;
                        end
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_DONE: begin
                if (start_pulse) begin
                    state_d = ST_WALK1;
                    hold_d  = '0;
                    k_d     = '0;
                    err_d   = '0;
                    blink_d = 1'b0;
                end else if (hold_last) begin
                    // The hold counter doubles as the blink half-period timer once the walk is over.
                    hold_d  = '0;
                    blink_d = ~blink_q;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pads.io_out             = '0;
        pads.io_oeb             = '1;
        pads.io_oeb[STATUS_PIN] = 1'b0;

        case (state_q)
            ST_WALK1, ST_WALK0: begin
                pads.io_out[NUM_IO-1:FIRST_TEST_PIN] = pattern;
                pads.io_oeb[NUM_IO-1:FIRST_TEST_PIN] = '0;
            end
            ST_DONE: begin
                pads.io_out[FIRST_TEST_PIN +: ERR_W] = err_q;
                pads.io_oeb[FIRST_TEST_PIN +: ERR_W] = '0;
                pads.io_out[STATUS_PIN]              = (err_q == '0) | blink_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_io_walk_sequencer.sv
// Self-checking bench: randomized pad faults against a step-level reference model.
module tb_io_walk_sequencer;
    localparam int NUM_IO = 31;
    localparam int H      = 4;
    localparam int W      = NUM_IO - 2;
    localparam int RUN    = 2 * W * H;

    localparam logic [31:0] RST_OEB  = 32'h7FFF_FFFD;
    localparam logic [31:0] WALK_OEB = 32'h0000_0001;
    localparam logic [31:0] DONE_OEB = 32'h7FFF_FC01;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] stk0 = '0;
    logic [W-1:0] stk1 = '0;

    int n_chk  = 0;
    int n_fail = 0;

    io_walk_sequencer_if #(.NUM_IO(NUM_IO)) pif ();

    // Pad model: driven pins loop back, with optional stuck-at-0 / stuck-at-1 faults.
    assign pif.io_in = {((pif.io_out[NUM_IO-1:2] & ~stk0) | stk1), pif.io_out[1], start};

    io_walk_sequencer #(.NUM_IO(NUM_IO), .HOLD_CYCLES(H)) dut (
        .clk  (clk),
        .rst  (rst),
        .pads (pif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] step_drive(input int ph, input int k);
        logic [W-1:0] d;
        d = '0;
        d[k] = 1'b1;
        return (ph == 0) ? d : ~d;
    endfunction

    function automatic int model_err(input logic [W-1:0] s0, input logic [W-1:0] s1);
        int e;
        logic [W-1:0] d;
        e = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < W; k++) begin
                d = step_drive(ph, k);
                if (((d & ~s0) | s1) != d) e++;
            end
        end
        return (e > 255) ? 255 : e;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_out"}, 32'(pif.io_out), 32'h0);
        chk({tag, "_oeb"}, 32'(pif.io_oeb), RST_OEB);
    endtask

    task automatic do_run(input logic [W-1:0] s0, input logic [W-1:0] s1,
                          input int repulse_at, input int abort_at, input bit keep_high,
                          input int done_cycles);
        int e;
        int ph;
        int k;
        logic [31:0] exp_out;
        logic st;
        stk0 = s0;
        stk1 = s1;
        e = model_err(s0, s1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!keep_high) start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("latency_not_yet", 32'(&pif.io_oeb[NUM_IO-1:10]), 32'h1);
        for (int t = 0; t < RUN; t++) begin
            @(negedge clk);
            ph = t / (W * H);
            k  = (t % (W * H)) / H;
            chk("walk_pat", 32'(pif.io_out[NUM_IO-1:2]), 32'(step_drive(ph, k)));
            chk("walk_oeb", 32'(pif.io_oeb), WALK_OEB);
            if (!keep_high && t == repulse_at) start = 1'b1;
            if (!keep_high && t == repulse_at + 1) start = 1'b0;
            if (t == abort_at) begin
                #2 rst = 1'b1;
                #1 check_reset_vals("abort_async");
                @(negedge clk);
                check_reset_vals("abort_hold");
                rst = 1'b0;
                @(negedge clk);
                check_reset_vals("abort_after");
                return;
            end
        end
        for (int c = 0; c < done_cycles; c++) begin
            @(negedge clk);
            st = (e == 0) ? 1'b1 : (((c / H) % 2) == 0);
            exp_out = {21'h0, 8'(e), st, 1'b0};
            chk("done_out", 32'(pif.io_out), exp_out);
            chk("done_oeb", 32'(pif.io_oeb), DONE_OEB);
        end
    endtask

    initial begin
        logic [W-1:0] r0;
        logic [W-1:0] r1;

        // reset held, then released with no start
        #1 check_reset_vals("por");
        @(negedge clk);
        check_reset_vals("por_clk");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_reset_vals("idle");
        end
        #2 rst = 1'b1;
        #1 check_reset_vals("idle_async_rst");
        @(negedge clk);
        rst = 1'b0;

        // ideal loopback with an ignored start pulse during WALK0
        do_run('0, '0, W * H + 20, -1, 1'b0, 4 * H);
        // pin 5 stuck at 0
        do_run(W'(1) << 3, '0, -1, -1, 1'b0, 4 * H);
        // restart from DONE must clear err
        do_run('0, '0, -1, -1, 1'b0, 2 * H);
        // all test pins stuck at 1
        do_run('0, '1, -1, -1, 1'b0, 4 * H);
        // random sparse faults
        for (int i = 0; i < 2; i++) begin
            r0 = W'($urandom) & W'($urandom) & W'($urandom);
            r1 = W'($urandom) & W'($urandom) & W'($urandom) & ~r0;
            do_run(r0, r1, -1, -1, 1'b0, 3 * H);
        end

        // start held high for ~500 cycles yields a single run
        do_run('0, '0, -1, -1, 1'b1, 2 * H);
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (i % 25 == 0) begin
                chk("held_start_done_oeb", 32'(pif.io_oeb), DONE_OEB);
                chk("held_start_done_out", 32'(pif.io_out), 32'h2);
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);

        // reset during WALK1 step 10, then a fresh full run
        do_run(W'(1) << 7, '0, -1, 10 * H + 1, 1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_reset_vals("post_abort_idle");
        end
        do_run('0, '0, -1, -1, 1'b0, 2 * H);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
